// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bus: pipeline writeback, SAD result stream,
// decode hazard query and the arbitrated register-file write port.
interface regfile_write_arbiter_if #(
   parameter int DEPTH = 4
);
   logic                     WB_RegWrite;
   logic [4:0]               WB_WriteRegister;
   logic [31:0]              WB_WriteData;
   logic                     SAD_Valid;
   logic [4:0]               SAD_WriteRegister;
   logic [31:0]              SAD_WriteData;
   logic                     SAD_Ready;
   logic [4:0]               ID_rs;
   logic [4:0]               ID_rt;
   logic [4:0]               ID_WriteRegister;
   logic                     ID_sad_hazard;
   logic                     WB_stall;
   logic                     RF_RegWrite;
   logic [4:0]               RF_WriteRegister;
   logic [31:0]              RF_WriteData;
   logic [$clog2(DEPTH):0]   Fifo_count;

   modport master (
      output WB_RegWrite, WB_WriteRegister, WB_WriteData,
      output SAD_Valid, SAD_WriteRegister, SAD_WriteData,
      output ID_rs, ID_rt, ID_WriteRegister,
      input  SAD_Ready, ID_sad_hazard, WB_stall,
      input  RF_RegWrite, RF_WriteRegister, RF_WriteData,
      input  Fifo_count
   );

   modport slave (
      input  WB_RegWrite, WB_WriteRegister, WB_WriteData,
      input  SAD_Valid, SAD_WriteRegister, SAD_WriteData,
      input  ID_rs, ID_rt, ID_WriteRegister,
      output SAD_Ready, ID_sad_hazard, WB_stall,
      output RF_RegWrite, RF_WriteRegister, RF_WriteData,
      output Fifo_count
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and a SAD result
// FIFO, with starvation forcing and a decode hazard flag for queued SAD writes.
module regfile_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input logic                   Clk,
   input logic                   Rst_n,
   regfile_write_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic [SW-1:0]  starve_cnt;
   logic [4:0]     q_reg  [DEPTH];
   logic [31:0]    q_data [DEPTH];

   logic             wb_req;
   logic             sad_req;
   logic             force_sad;
   logic             grant_wb;
   logic             grant_sad;
   logic             ready;
   logic             push;
   logic [DEPTH-1:0] slot_valid;
   logic [4:0]       id_src [3];
   logic             hazard;

   function automatic logic [CW-1:0] age(input int i,
                                         input logic [AW-1:0] rp);
      logic [AW-1:0] d;
      d = AW'(i) - rp;
      return {1'b0, d};
   endfunction

   always_comb begin
      wb_req    = Rst_n & bus.WB_RegWrite
                & (bus.WB_WriteRegister != 5'd0);
      sad_req   = (count != '0);
      force_sad = sad_req & (starve_cnt == SW'(STARVE_LIMIT));
      grant_wb  = wb_req & ~force_sad;
      grant_sad = ~grant_wb & sad_req;
      ready     = Rst_n & (count < CW'(DEPTH));
      push      = bus.SAD_Valid & ready
                & (bus.SAD_WriteRegister != 5'd0);
   end

   // Slot i holds a live entry when its distance from the head is < count.
   always_comb begin
      slot_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_valid[i] = age(i, rd_ptr) < count;
      end
   end

   always_comb begin
      id_src[0] = bus.ID_rs;
      id_src[1] = bus.ID_rt;
      id_src[2] = bus.ID_WriteRegister;
      hazard    = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (id_src[k] != 5'd0) begin
            if (push && id_src[k] == bus.SAD_WriteRegister) begin
               hazard = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
               if (slot_valid[i] && q_reg[i] == id_src[k]) begin
                  hazard = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      bus.RF_RegWrite      = 1'b0;
      bus.RF_WriteRegister = 5'd0;
      bus.RF_WriteData     = 32'd0;
      unique case (1'b1)
         grant_wb: begin
            bus.RF_RegWrite      = 1'b1;
            bus.RF_WriteRegister = bus.WB_WriteRegister;
            bus.RF_WriteData     = bus.WB_WriteData;
         end
         grant_sad: begin
            bus.RF_RegWrite      = 1'b1;
            bus.RF_WriteRegister = q_reg[rd_ptr];
            bus.RF_WriteData     = q_data[rd_ptr];
         end
         default: ;
      endcase
      bus.WB_stall      = wb_req & force_sad;
      bus.SAD_Ready     = ready;
      bus.ID_sad_hazard = Rst_n & hazard;
      bus.Fifo_count    = count;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (grant_sad) rd_ptr <= rd_ptr + 1'b1;
         if (push && !grant_sad) count <= count + 1'b1;
         else if (!push && grant_sad) count <= count - 1'b1;
         if (grant_sad || count == '0) begin
            starve_cnt <= '0;
         end else if (grant_wb && starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   // Storage needs no reset: validity is tracked by the pointers and count.
   always_ff @(posedge Clk) begin
      if (push) begin
         q_reg[wr_ptr]  <= bus.SAD_WriteRegister;
         q_data[wr_ptr] <= bus.SAD_WriteData;
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle vector table plus a SAD
// result scoreboard for the fill/drain and asynchronous reset sequences.
module tb_regfile_write_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   regfile_write_arbiter_if #(.DEPTH(4)) bus ();

   regfile_write_arbiter #(
      .DEPTH(4),
      .STARVE_LIMIT(3)
   ) dut (
      .Clk  (clk),
      .Rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_reg;
      logic [31:0] wb_data;
      logic        sad_v;
      logic [4:0]  sad_reg;
      logic [31:0] sad_data;
      logic [4:0]  rs, rt, wr;
      logic        e_we;
      logic [4:0]  e_reg;
      logic [31:0] e_data;
      logic        e_stall, e_rdy, e_haz;
      logic [2:0]  e_cnt;
   } vec_t;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   vec_t vt [18];
   wr_t  sad_q [$];

   function automatic vec_t mk(int wbw, int wrg, int wd, int sv, int sr,
                               int sd, int rs, int rt, int idw, int ew,
                               int er, int ed, int es, int ey, int eh,
                               int ec);
      vec_t v;
      v.wb_we    = wbw[0];
      v.wb_reg   = wrg[4:0];
      v.wb_data  = wd;
      v.sad_v    = sv[0];
      v.sad_reg  = sr[4:0];
      v.sad_data = sd;
      v.rs       = rs[4:0];
      v.rt       = rt[4:0];
      v.wr       = idw[4:0];
      v.e_we     = ew[0];
      v.e_reg    = er[4:0];
      v.e_data   = ed;
      v.e_stall  = es[0];
      v.e_rdy    = ey[0];
      v.e_haz    = eh[0];
      v.e_cnt    = ec[2:0];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic wbw, input logic [4:0] wrg,
                        input logic [31:0] wd, input logic sv,
                        input logic [4:0] sr, input logic [31:0] sd);
      bus.WB_RegWrite       = wbw;
      bus.WB_WriteRegister  = wrg;
      bus.WB_WriteData      = wd;
      bus.SAD_Valid         = sv;
      bus.SAD_WriteRegister = sr;
      bus.SAD_WriteData     = sd;
   endtask

   // src: 0 no write, 1 writeback write, 2 SAD write from scoreboard head
   task automatic cyc(input string nm, input logic wbw,
                      input logic [4:0] wrg, input logic [31:0] wd,
                      input logic sv, input logic [4:0] sr,
                      input logic [31:0] sd, input int src,
                      input logic es, input logic ey, input int ec,
                      input logic acc);
      wr_t e;
      drive(wbw, wrg, wd, sv, sr, sd);
      if (acc) sad_q.push_back('{sr, sd});
      @(negedge clk);
      chk({nm, " stall"}, 32'(bus.WB_stall), 32'(es));
      chk({nm, " ready"}, 32'(bus.SAD_Ready), 32'(ey));
      chk({nm, " count"}, 32'(bus.Fifo_count), 32'(ec));
      if (src == 0) begin
         chk({nm, " rf_we"}, 32'(bus.RF_RegWrite), 32'd0);
      end else begin
         chk({nm, " rf_we"}, 32'(bus.RF_RegWrite), 32'd1);
         if (src == 1) begin
            chk({nm, " rf_reg"}, 32'(bus.RF_WriteRegister), 32'(wrg));
            chk({nm, " rf_data"}, bus.RF_WriteData, wd);
         end else if (sad_q.size() == 0) begin
            chk({nm, " sad_q_empty"}, 32'd0, 32'd1);
         end else begin
            e = sad_q.pop_front();
            chk({nm, " sad_reg"}, 32'(bus.RF_WriteRegister), 32'(e.r));
            chk({nm, " sad_data"}, bus.RF_WriteData, e.d);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " rf_we"}, 32'(bus.RF_RegWrite), 32'd0);
      chk({nm, " rf_reg"}, 32'(bus.RF_WriteRegister), 32'd0);
      chk({nm, " rf_data"}, bus.RF_WriteData, 32'd0);
      chk({nm, " stall"}, 32'(bus.WB_stall), 32'd0);
      chk({nm, " ready"}, 32'(bus.SAD_Ready), 32'd0);
      chk({nm, " hazard"}, 32'(bus.ID_sad_hazard), 32'd0);
      chk({nm, " count"}, 32'(bus.Fifo_count), 32'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      vt[0]  = mk(1, 8, 'h11, 0, 0, 0, 0, 0, 0, 1, 8, 'h11, 0, 1, 0, 0);
      vt[1]  = mk(0, 0, 0, 1, 5, 'hAAAA, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      vt[2]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 5, 'hAAAA, 0, 1, 1, 1);
      vt[3]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      vt[4]  = mk(0, 0, 0, 1, 7, 'h7777, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      vt[5]  = mk(1, 1, 'h101, 0, 0, 0, 0, 0, 0, 1, 1, 'h101, 0, 1, 0, 1);
      vt[6]  = mk(1, 2, 'h102, 0, 0, 0, 0, 0, 0, 1, 2, 'h102, 0, 1, 0, 1);
      vt[7]  = mk(1, 3, 'h103, 0, 0, 0, 0, 0, 0, 1, 3, 'h103, 0, 1, 0, 1);
      vt[8]  = mk(1, 4, 'h104, 0, 0, 0, 0, 0, 0, 1, 7, 'h7777, 1, 1, 0, 1);
      vt[9]  = mk(1, 4, 'h104, 0, 0, 0, 0, 0, 0, 1, 4, 'h104, 0, 1, 0, 0);
      vt[10] = mk(1, 5, 'h105, 0, 0, 0, 0, 0, 0, 1, 5, 'h105, 0, 1, 0, 0);
      vt[11] = mk(1, 6, 'h106, 0, 0, 0, 0, 0, 0, 1, 6, 'h106, 0, 1, 0, 0);
      vt[12] = mk(1, 0, 'h99, 1, 0, 'h5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      vt[14] = mk(0, 0, 0, 1, 9, 'h9, 0, 0, 9, 0, 0, 0, 0, 1, 1, 0);
      vt[15] = mk(1, 10, 'hA0, 0, 0, 0, 0, 9, 0, 1, 10, 'hA0, 0, 1, 1, 1);
      vt[16] = mk(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 9, 'h9, 0, 1, 0, 1);
      vt[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // Reset held with both requesters active
      rst_n = 1'b0;
      drive(1'b1, 5'd8, 32'h11, 1'b1, 5'd3, 32'h33);
      bus.ID_rs            = 5'd3;
      bus.ID_rt            = 5'd0;
      bus.ID_WriteRegister = 5'd0;
      #12;
      chk_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         drive(vt[i].wb_we, vt[i].wb_reg, vt[i].wb_data,
               vt[i].sad_v, vt[i].sad_reg, vt[i].sad_data);
         bus.ID_rs            = vt[i].rs;
         bus.ID_rt            = vt[i].rt;
         bus.ID_WriteRegister = vt[i].wr;
         @(negedge clk);
         chk($sformatf("row%0d rf_we", i),
             32'(bus.RF_RegWrite), 32'(vt[i].e_we));
         chk($sformatf("row%0d rf_reg", i),
             32'(bus.RF_WriteRegister), 32'(vt[i].e_reg));
         chk($sformatf("row%0d rf_data", i),
             bus.RF_WriteData, vt[i].e_data);
         chk($sformatf("row%0d stall", i),
             32'(bus.WB_stall), 32'(vt[i].e_stall));
         chk($sformatf("row%0d ready", i),
             32'(bus.SAD_Ready), 32'(vt[i].e_rdy));
         chk($sformatf("row%0d hazard", i),
             32'(bus.ID_sad_hazard), 32'(vt[i].e_haz));
         chk($sformatf("row%0d count", i),
             32'(bus.Fifo_count), 32'(vt[i].e_cnt));
         @(posedge clk);
         #1;
      end
      bus.ID_rs = 5'd0;
      bus.ID_rt = 5'd0;
      bus.ID_WriteRegister = 5'd0;

      // Fill behind writeback traffic, full stall, then in-order drain
      cyc("fill0", 1, 11, 'hB1, 1, 20, 'hC1, 1, 0, 1, 0, 1);
      cyc("fill1", 1, 12, 'hB2, 1, 21, 'hC2, 1, 0, 1, 1, 1);
      cyc("fill2", 1, 13, 'hB3, 1, 22, 'hC3, 1, 0, 1, 2, 1);
      cyc("fill3", 1, 14, 'hB4, 1, 23, 'hC4, 1, 0, 1, 3, 1);
      cyc("full",  1, 15, 'hB5, 1, 24, 'hC5, 2, 1, 0, 4, 0);
      cyc("push5", 1, 15, 'hB5, 1, 24, 'hC5, 1, 0, 1, 3, 1);
      cyc("drain0", 0, 0, 0, 0, 0, 0, 2, 0, 0, 4, 0);
      cyc("drain1", 0, 0, 0, 0, 0, 0, 2, 0, 1, 3, 0);
      cyc("drain2", 0, 0, 0, 0, 0, 0, 2, 0, 1, 2, 0);
      cyc("drain3", 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0);
      cyc("drained", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("sad_q leftover", 32'(sad_q.size()), 32'd0);

      // Queue three entries, then reset asynchronously between edges
      cyc("pre0", 1, 1, 'hD1, 1, 25, 'hE1, 1, 0, 1, 0, 1);
      cyc("pre1", 1, 2, 'hD2, 1, 26, 'hE2, 1, 0, 1, 1, 1);
      cyc("pre2", 1, 3, 'hD3, 1, 27, 'hE3, 1, 0, 1, 2, 1);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("pre_rst count", 32'(bus.Fifo_count), 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      sad_q.delete();
      drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd28, 32'hE4);
      bus.ID_rs = 5'd28;
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      bus.ID_rs = 5'd0;
      rst_n = 1'b1;
      cyc("post0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc("post1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc("post2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Arbitrates the single register-file write port between two requesters: the pipeline writeback stage and the SAD accelerator's result stream. SAD results are buffered in a small in-order FIFO. Pipeline writes normally win, and a starvation counter forces SAD drains when needed. The block also produces the decode-stage hazard flag for registers with queued SAD writes. It sits between MEM/WB, the SAD unit and the register file. The decode bypass compares against its RF_* outputs.

Parameters:
DEPTH, 4, SAD result FIFO entries (power of two, >=2)
STARVE_LIMIT, 3, max consecutive pipeline grants while FIFO non-empty before SAD is forced

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  reset, asynchronous, active-low
WB_RegWrite  in  1  pipeline write request
WB_WriteRegister  in  5  pipeline destination
WB_WriteData  in  32  pipeline data
SAD_Valid  in  1  SAD result offered
SAD_WriteRegister  in  5  SAD destination
SAD_WriteData  in  32  SAD data
SAD_Ready  out  1  FIFO can accept (count < DEPTH)
ID_rs  in  5  decode source rs
ID_rt  in  5  decode source rt
ID_WriteRegister  in  5  decode destination (0 if none)
ID_sad_hazard  out  1  decode must stall
WB_stall  out  1  pipeline must hold MEM/WB this cycle
RF_RegWrite  out  1  register-file write enable
RF_WriteRegister  out  5  register-file write address
RF_WriteData  out  32  register-file write data
Fifo_count  out  $clog2(DEPTH)+1  queued SAD entries

Behaviour:
- Reset: async assert clears FIFO pointers/count and starve_cnt.
  - While Rst_n=0: RF_RegWrite=0, WB_stall=0, SAD_Ready=0, ID_sad_hazard=0, Fifo_count=0, RF_WriteRegister=0, RF_WriteData=0.
  - Reset mid-operation discards queued entries; no write is issued.
- Requests:
  - wb_req = WB_RegWrite & (WB_WriteRegister != 0).
  - sad_req = (count != 0).
- Grant, combinational, same cycle:
  - force = sad_req & (starve_cnt == STARVE_LIMIT).
  - If wb_req & !force: grant pipeline. RF_* = WB_*.
  - Else if sad_req: grant FIFO head and pop at the edge. RF_* = head.
  - Else: RF_RegWrite=0, RF_WriteRegister=0, RF_WriteData=0.
  - WB_stall = wb_req & force. The pipeline re-presents the same request next cycle.
- starve_cnt:
  - Cleared on any SAD grant or when count==0.
  - Otherwise increments, saturating at STARVE_LIMIT, on each pipeline grant with sad_req=1.
  - Holds in all other cases.
- Push:
  - Occurs at the edge when SAD_Valid & SAD_Ready & (SAD_WriteRegister != 0).
  - SAD_Valid & SAD_Ready with register 0: accepted, not enqueued.
  - SAD_Ready = (count < DEPTH), from registered count only. There is no same-cycle pop bypass: a full FIFO deasserts Ready even when popping.
  - A pushed entry becomes the head no earlier than the next cycle; there is no empty-FIFO bypass.
- Push+pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- Order: SAD entries are written strictly in arrival order.
- ID_sad_hazard is set when any nonzero register among ID_rs, ID_rt, ID_WriteRegister matches either:
  - a valid queued entry, or
  - the SAD_WriteRegister of a push accepted this cycle.
  - Effect: prevents RAW on SAD results and WAW between pipeline and SAD writes.
  - An entry being popped this cycle still counts as a match. Its data reaches decode via RF_* bypass, and the stall costs at most one extra cycle.
- Latency:
  - Pipeline write: 0 cycles, port write at the edge.
  - SAD write: at least 1 cycle after acceptance.
  - Worst-case SAD head wait with a continuous pipeline stream: STARVE_LIMIT cycles.
- Fifo_count is registered and is the count after the last edge.

Test Plan:
- Reset with SAD_Valid=1 and WB_RegWrite=1 held -> all outputs 0; the first edge after Rst_n=1 with WB (r8, 0x11) gives RF_RegWrite=1, RF_WriteRegister=8, no stall.
- Push SAD (r5, 0xAAAA) with no WB traffic -> Fifo_count=1 next cycle, and RF write r5=0xAAAA in that cycle. ID_rs=5 raises ID_sad_hazard in the push cycle and in the pop cycle, and clears after.
- Queue one SAD entry, then drive continuous WB writes r1..r6 -> WB wins for exactly 3 cycles. In cycle 4 WB_stall=1 and the SAD entry is written. The held WB write completes in cycle 5.
- Fill the FIFO with 4 pushes -> SAD_Ready=0 and Fifo_count=4. A simultaneous pop and SAD_Valid leaves the 5th result unaccepted. The next cycle Ready=1, the 5th result is accepted, and the 4 queued results drain in push order.
- SAD push to r0, plus WB_RegWrite=1 to r0 -> no enqueue, Fifo_count unchanged, RF_RegWrite=0, no hazard.
- Assert Rst_n=0 asynchronously mid-cycle with 3 entries queued -> Fifo_count=0 and RF_RegWrite=0 immediately, and no queued writes appear after release.
